int_controller: RTL

Memory-mapped interrupt controller sitting directly upstream of `core`, driving its `INT0`/`INT1` inputs. It edge-detects eight asynchronous IRQ lines, latches them as pending, and applies a mask and a global enable. It exposes pending, mask, vector and control registers on the core's external bus (`ADDR_BUF`, `DOUT_BUF`, `RDN_BUF`, `WRN0_BUF`, `WRN1_BUF`). Software acknowledges an interrupt by reading the vector register, which returns the highest-priority source and clears it.

---
 rtl/intc_pkg.sv | 29 ++
 rtl/int_controller_if.sv | 21 ++
 rtl/irq_sync_edge.sv | 26 ++
 rtl/int_controller.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the memory-mapped interrupt controller: register offsets,
// vector-register layout, bus FSM states and the source priority encoder.
package intc_pkg;

  // Register select values taken from ADDR[2:1]
  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_VEC  = 2'd2;
  localparam logic [1:0] INTC_CTRL = 2'd3;

  localparam int unsigned INTC_VEC_V_BIT = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } bus_state_e;

  // Lowest-numbered set bit wins; returns 0 when nothing is set.
  function automatic logic [2:0] prio_idx(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// Core external-bus signals seen by the interrupt controller (ADDR_BUF, DOUT_BUF,
// RDN_BUF, WRN0_BUF, WRN1_BUF) plus its read-data and DIN-mux select returns.
interface int_controller_if;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic        RDN;
  logic        WRN0;
  logic        WRN1;
  logic [15:0] RDATA;
  logic        SEL;

  modport master (
    output ADDR, WDATA, RDN, WRN0, WRN1,
    input  RDATA, SEL
  );

  modport slave (
    input  ADDR, WDATA, RDN, WRN0, WRN1,
    output RDATA, SEL
  );
endinterface

// File: rtl/irq_sync_edge.sv
// One IRQ line: two-flop synchroniser followed by a history flop for rising-edge
// detection. rise is high for exactly one cycle per synchronised low-to-high edge.
module irq_sync_edge (
  input  logic CLK,
  input  logic RESETN,
  input  logic irq,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller in front of the core: latches IRQ edges as pending, masks them,
// and exposes PEND/MASK/VEC/CTRL on the core bus. Reading VEC acknowledges the winner.
module int_controller
  import intc_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hFF00,
  parameter int unsigned NSRC = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [7:0]       IRQ,
  int_controller_if.slave  bus,
  output logic             INT0,
  output logic             INT1
);

  logic [7:0] rise;

  for (genvar i = 0; i < NSRC; i++) begin : gen_sync
    irq_sync_edge u_sync (
      .CLK    (CLK),
      .RESETN (RESETN),
      .irq    (IRQ[i]),
      .rise   (rise[i])
    );
  end

  bus_state_e state_q;
  logic [7:0] pend_q, pend_d, mask_q, clr;
  logic       gen_q;
  logic       int0_q, int1_q;
  logic       rdn_q, rdn_prev_q, wrn0_q, wrn0_prev_q;
  logic       ack_vec_q, ack_v_q;
  logic [2:0] ack_idx_q;

  logic       in_win;
  logic [1:0] reg_sel;
  logic [7:0] eligible;
  logic       vec_v;
  logic [2:0] vec_idx;
  logic [15:0] vec_word;
  logic       rd_fall, rd_rise, wr_fall, wr_rise;
  logic       start_rd, start_wr, ack;
  logic       unused_bits;

  // WRN1 and the high write byte carry nothing: every register lives in the low byte.
  assign unused_bits = ^{bus.WRN1, bus.WDATA[15:8], bus.ADDR[0]};

  assign in_win   = (bus.ADDR[15:3] == BASE[15:3]);
  assign reg_sel  = bus.ADDR[2:1];
  assign eligible = pend_q & mask_q;
  assign vec_v    = |eligible;
  assign vec_idx  = prio_idx(eligible);

  always_comb begin
    vec_word                 = '0;
    vec_word[INTC_VEC_V_BIT] = vec_v;
    vec_word[2:0]            = vec_idx;
  end

  // Edges are taken on the registered strobes so each access commits exactly once.
  assign rd_fall = ~rdn_q & rdn_prev_q;
  assign rd_rise = rdn_q & ~rdn_prev_q;
  assign wr_fall = ~wrn0_q & wrn0_prev_q;
  assign wr_rise = wrn0_q & ~wrn0_prev_q;

  assign bus.SEL = in_win & ~bus.RDN;

  always_comb begin
    bus.RDATA = '0;
    if (bus.SEL) begin
      case (reg_sel)
        INTC_PEND: bus.RDATA = {8'h00, pend_q};
        INTC_MASK: bus.RDATA = {8'h00, mask_q};
        INTC_VEC:  bus.RDATA = vec_word;
        default:   bus.RDATA = {15'h0000, gen_q};
      endcase
    end
  end

  always_comb begin
    start_rd = (state_q == StIdle) && rd_fall && in_win;
    // A read strobe already low blocks the write entirely.
    start_wr = (state_q == StIdle) && wr_fall && in_win && rdn_q;
    ack      = (state_q == StRd) && rd_rise && ack_vec_q && ack_v_q;
    clr      = '0;
    if (start_wr && (reg_sel == INTC_PEND)) clr = bus.WDATA[7:0];
    if (ack) clr = clr | (8'd1 << ack_idx_q);
    // New edges override any clear landing on the same bit.
    pend_d   = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      mask_q      <= '0;
      gen_q       <= 1'b0;
      int0_q      <= 1'b0;
      int1_q      <= 1'b0;
      rdn_q       <= 1'b0;
      rdn_prev_q  <= 1'b0;
      wrn0_q      <= 1'b0;
      wrn0_prev_q <= 1'b0;
      ack_vec_q   <= 1'b0;
      ack_v_q     <= 1'b0;
      ack_idx_q   <= '0;
    end else begin
      rdn_q       <= bus.RDN;
      rdn_prev_q  <= rdn_q;
      wrn0_q      <= bus.WRN0;
      wrn0_prev_q <= wrn0_q;
      pend_q      <= pend_d;
      int0_q      <= gen_q & |(pend_q[3:0] & mask_q[3:0]);
      int1_q      <= gen_q & |(pend_q[7:4] & mask_q[7:4]);
      case (state_q)
        StIdle: begin
          if (start_rd) begin
            state_q   <= StRd;
            // Snapshot the vector the core is about to sample; this is what gets cleared.
            ack_vec_q <= (reg_sel == INTC_VEC);
            ack_v_q   <= vec_v;
            ack_idx_q <= vec_idx;
          end else if (start_wr) begin
            state_q <= StWr;
            if (reg_sel == INTC_MASK) mask_q <= bus.WDATA[7:0];
            if (reg_sel == INTC_CTRL) gen_q <= bus.WDATA[0];
          end
        end
        StRd: begin
          if (rd_rise) state_q <= StIdle;
        end
        StWr: begin
          if (wr_rise) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign INT0 = int0_q;
  assign INT1 = int1_q;

endmodule
